// File: rtl/miriscv_data_arbiter.sv
// Two-master data-port arbiter: owner alternates via a round-robin pointer
// and a single transaction is outstanding at a time.
module miriscv_data_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                arb_busy_o
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_q, state_d;
    logic                ptr_q;
    logic                owner_p0;
    logic                we_p0;
    logic [BE_W-1:0]     be_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   wdata_p0;

    logic                any_req;
    logic                winner;

    // A lone requester wins outright; a tie is broken by the pointer.
    assign any_req = m0_req_i | m1_req_i;
    assign winner  = (m0_req_i & m1_req_i) ? ptr_q : m1_req_i;

    always_comb begin
        state_d     = state_q;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = REQ;
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_p0;
                mem_be_o    = be_p0;
                mem_addr_o  = addr_p0;
                mem_wdata_o = wdata_p0;
                if (mem_gnt_i) begin
                    m0_gnt_o = ~owner_p0;
                    m1_gnt_o = owner_p0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    m0_rvalid_o = ~owner_p0;
                    m1_rvalid_o = owner_p0;
                    m0_rdata_o  = owner_p0 ? '0 : mem_rdata_i;
                    m1_rdata_o  = owner_p0 ? mem_rdata_i : '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arb_busy_o = (state_q != IDLE);

    // Request latch stage: payload frozen here so master-side changes are invisible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_p0 <= 1'b0;
            we_p0    <= 1'b0;
            be_p0    <= '0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                owner_p0 <= winner;
                we_p0    <= winner ? m1_we_i    : m0_we_i;
                be_p0    <= winner ? m1_be_i    : m0_be_i;
                addr_p0  <= winner ? m1_addr_i  : m0_addr_i;
                wdata_p0 <= winner ? m1_wdata_i : m0_wdata_i;
            end
            if (state_q == RESP && mem_rvalid_i) ptr_q <= ~owner_p0;
        end
    end

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Scoreboard bench for miriscv_data_arbiter: expected transactions are queued
// when masters are driven and checked as the memory side serves them.
module tb_miriscv_data_arbiter;

    logic        clk;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        arb_busy_o;

    typedef struct {
        logic        owner;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    miriscv_data_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .arb_busy_o(arb_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic set_m(input bit idx, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (idx) begin
            m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
        end
    endtask

    task automatic push_exp(input logic owner, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.owner = owner; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    // Memory responder: waits for mem_req_o, holds gnt off for gnt_delay cycles,
    // then rvalid after rv_delay idle RESP cycles; checks against the queue head.
    task automatic mem_serve(input int gnt_delay, input int rv_delay, output int waited);
        txn_t e;
        bit   found;
        logic og, xg;
        waited = 0;
        found  = 0;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected transaction queued");
            return;
        end
        e = exp_q[0];
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            #1;
            if (mem_req_o === 1'b1) found = 1;
            else waited++;
        end
        if (!found) begin
            n_fail++;
            $display("FAIL mem_req_timeout: mem_req_o=%b after 20 cycles, required 1", mem_req_o);
            void'(exp_q.pop_front());
            return;
        end
        for (int d = 0; d <= gnt_delay; d++) begin
            if (d > 0) begin step(); #1; end
            n_tests++;
            if (mem_req_o !== 1'b1 || mem_we_o !== e.we || mem_be_o !== e.be ||
                mem_addr_o !== e.addr || mem_wdata_o !== e.wdata || arb_busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL mem_payload: req=%b we=%b be=%h addr=%h wdata=%h busy=%b, required 1 %b %h %h %h 1",
                         mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, arb_busy_o,
                         e.we, e.be, e.addr, e.wdata);
            end
            if (d < gnt_delay) begin
                n_tests++;
                if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gnt_early: m0_gnt=%b m1_gnt=%b, required 0 0", m0_gnt_o, m1_gnt_o);
                end
            end
        end
        mem_gnt_i = 1'b1;
        #1;
        og = e.owner ? m1_gnt_o : m0_gnt_o;
        xg = e.owner ? m0_gnt_o : m1_gnt_o;
        n_tests++;
        if (og !== 1'b1 || xg !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_owner: owner(m%0d)_gnt=%b other_gnt=%b, required 1 0", e.owner, og, xg);
        end
        step();
        for (int d = 0; d < rv_delay; d++) begin
            #1;
            n_tests++;
            if (mem_req_o !== 1'b0 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || arb_busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL resp_wait: mem_req=%b m0_rv=%b m1_rv=%b busy=%b, required 0 0 0 1",
                         mem_req_o, m0_rvalid_o, m1_rvalid_o, arb_busy_o);
            end
            step();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = e.rdata;
        #1;
        n_tests++;
        if (e.owner) begin
            if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== e.rdata || m0_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL rvalid_m1: m1_rv=%b m1_rdata=%h m0_rv=%b m0_rdata=%h, required 1 %h 0 0",
                         m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o, e.rdata);
            end
        end else begin
            if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== e.rdata || m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL rvalid_m0: m0_rv=%b m0_rdata=%h m1_rv=%b m1_rdata=%h, required 1 %h 0 0",
                         m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o, e.rdata);
            end
        end
        void'(exp_q.pop_front());
    endtask

    task automatic check_quiet(input string name);
        n_tests++;
        if (arb_busy_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'h0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 ||
            m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h0 || m1_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: busy=%b mem_req=%b addr=%h gnt=%b%b rv=%b%b rdata=%h/%h, required all 0",
                     name, arb_busy_o, mem_req_o, mem_addr_o, m0_gnt_o, m1_gnt_o,
                     m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_quiet("reset_idle");
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
        step();
        #1;
        n_tests++;
        if (arb_busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_req: busy=%b mem_req=%b, required 1 1", arb_busy_o, mem_req_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check_quiet("reset_mid_req");
    endtask

    task automatic test_single_read();
        int w;
        do_reset();
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        mem_serve(0, 0, w);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_tests++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL single_latency: mem_req_o after %0d extra cycles, required 0", w);
        end
        step();
        #1;
        check_quiet("single_back_idle");
    endtask

    task automatic test_back_to_back();
        int w;
        do_reset();
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        set_m(1, 1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_0001);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h1111_0000 + k);
            else            push_exp(1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_0001, 32'h2222_0000 + k);
        end
        for (int k = 0; k < 4; k++) begin
            mem_serve(0, 0, w);
            n_tests++;
            if (w != (k == 0 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL b2b_gap_%0d: idle cycles before mem_req=%0d, required %0d", k, w, (k == 0 ? 0 : 1));
            end
        end
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        #1;
        check_quiet("b2b_idle");
    endtask

    task automatic test_gnt_stall();
        int w;
        do_reset();
        set_m(1, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
        push_exp(1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678, 32'h0);
        mem_serve(5, 1, w);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        #1;
        check_quiet("stall_idle");
    endtask

    task automatic test_addr_change();
        int w;
        do_reset();
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h0BAD_F00D);
        step();
        set_m(0, 1'b0, 1'b1, 4'h1, 32'h0000_0044, 32'hFFFF_FFFF);
        mem_serve(2, 2, w);
        step();
        #1;
        check_quiet("addr_change_idle");
    endtask

    task automatic test_reset_mid_resp();
        int w;
        do_reset();
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'h0);
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0060, 32'h0, 32'h5555_AAAA);
        mem_serve(0, 0, w);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0070, 32'h0);
        step();
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_gnt_i = 1'b1;
        step();
        #1;
        n_tests++;
        if (arb_busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_state: busy=%b mem_req=%b, required 1 0", arb_busy_o, mem_req_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check_quiet("reset_in_resp");
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        #1;
        check_quiet("stray_rvalid_after_reset");
        step();
        #1;
        check_quiet("after_stray_rvalid");
        // Pointer was 1 before reset; a tie must now go to m0.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0090, 32'h0);
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 32'h0101_0101);
        mem_serve(0, 0, w);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_stray_handshakes();
        int w;
        do_reset();
        mem_gnt_i = 1'b1;
        #1;
        check_quiet("stray_gnt_idle");
        step();
        #1;
        check_quiet("after_stray_gnt");
        set_m(1, 1'b1, 1'b1, 4'hF, 32'h0000_00A0, 32'hAAAA_5555);
        push_exp(1'b1, 1'b1, 4'hF, 32'h0000_00A0, 32'hAAAA_5555, 32'h0);
        step();
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h9999_9999;
        #1;
        n_tests++;
        if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h0 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_rvalid_req: rv=%b%b m1_rdata=%h mem_req=%b, required 0 0 0 1",
                     m0_rvalid_o, m1_rvalid_o, m1_rdata_o, mem_req_o);
        end
        step();
        #1;
        n_tests++;
        if (arb_busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_rvalid_hold: busy=%b mem_req=%b, required 1 1", arb_busy_o, mem_req_o);
        end
        mem_serve(0, 0, w);
        step();
        #1;
        check_quiet("stray_done_idle");
    endtask

    initial begin
        rst_i        = 1'b1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_gnt_stall();
        test_addr_change();
        test_reset_mid_resp();
        test_stray_handshakes();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/miriscv_data_arbiter.md
MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width (byte-enable width is DATA_W/8).
REQ-002 clk_i  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 m0_req_i / m1_req_i  input  1  requester 0 (core LSU) / requester 1 (debug/DMA) transaction request.
REQ-005 m0_we_i / m1_we_i  input  1  1 = write, 0 = read.
REQ-006 m0_be_i / m1_be_i  input  DATA_W/8  byte enables.
REQ-007 m0_addr_i / m1_addr_i  input  ADDR_W  byte address.
REQ-008 m0_wdata_i / m1_wdata_i  input  DATA_W  write data.
REQ-009 m0_gnt_o / m1_gnt_o  output  1  request accepted by memory; 1-cycle pulse.
REQ-010 m0_rvalid_o / m1_rvalid_o  output  1  response valid; 1-cycle pulse; issued for reads and writes.
REQ-011 m0_rdata_o / m1_rdata_o  output  DATA_W  read data; valid only with rvalid.
REQ-012 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1/1/DATA_W/8/ADDR_W/DATA_W  memory-side request.
REQ-013 mem_gnt_i, mem_rvalid_i  input  1 each; mem_rdata_i  input  DATA_W  memory-side grant/response.
REQ-014 arb_busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, REQ, RESP; one transaction outstanding at most.
REQ-016 IDLE: if any mX_req_i high, winner SHALL be latched (owner, we, be, addr, wdata registered) and state -> REQ next edge; otherwise stay IDLE.
REQ-017 Both requests high in IDLE: winner SHALL be the master indicated by the priority pointer; single request: that master wins regardless of pointer.
REQ-018 Priority pointer SHALL be 1 bit, reset to 0 (m0 preferred), and SHALL toggle to the non-owner when the owner's rvalid is issued.
REQ-019 REQ: mem_req_o = 1 and mem_we/be/addr/wdata_o SHALL be driven from the latched registers, stable until mem_gnt_i.
REQ-020 REQ with mem_gnt_i = 1: owner's mX_gnt_o SHALL be 1 in the same cycle (combinational), state -> RESP; otherwise hold REQ indefinitely.
REQ-021 RESP: mem_req_o = 0; on mem_rvalid_i = 1, owner's mX_rvalid_o = 1 and mX_rdata_o = mem_rdata_i in the same cycle, state -> IDLE.
REQ-022 Minimum latency: master req at cycle N (IDLE) -> mem_req_o at N+1; with gnt at N+1 and rvalid at N+2, next arbitration at N+3.
REQ-023 Non-owner gnt_o/rvalid_o SHALL be 0 and its rdata_o SHALL be 0 at all times; mem_* outputs SHALL be 0 outside REQ.
REQ-024 Master-side inputs changing after latching SHALL NOT affect the memory-side request.
REQ-025 mem_gnt_i outside REQ and mem_rvalid_i outside RESP SHALL be ignored (no state change, no pulses); bench flags as protocol error.
REQ-026 Master holding req_i after its rvalid SHALL be treated as a new request in IDLE subject to the toggled pointer.

Reset
REQ-027 rst_i = 1 at an edge SHALL force state IDLE, pointer 0, latched registers 0, all outputs 0 from the next cycle, including mid-REQ or mid-RESP.
REQ-028 Responses arriving after reset for an aborted transaction SHALL be ignored per REQ-025.

Verification
REQ-029 m0 single read addr 0x10, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> m0_gnt_o pulse at cycle 1, m0_rvalid_o with 0xDEADBEEF at cycle 2, m1 outputs all 0.
REQ-030 m0 and m1 both request continuously for 4 transactions -> owners m0, m1, m0, m1 in order; no master waits more than one transaction.
REQ-031 m1 write addr 0x20, wdata 0x12345678, be 4'b0011, gnt withheld 5 cycles -> mem_req_o and payload stable all 5 cycles, m1_gnt_o only on gnt cycle.
REQ-032 m0 changes addr from 0x40 to 0x44 after latching -> mem_addr_o stays 0x40 until rvalid.
REQ-033 rst_i asserted in RESP, then stray mem_rvalid_i -> outputs 0, state IDLE, no rvalid pulse, pointer 0.
REQ-034 mem_gnt_i asserted while IDLE and mem_rvalid_i asserted during REQ -> no gnt/rvalid pulses, state unchanged.
